// File: rtl/fpexc_pipe.sv
// Floating-point exception/special-case stage: classifies operands, derives IEEE flags and
// result-override controls, and registers them behind a one-deep valid/ready output stage.
module fpexc_pipe #(
  parameter int unsigned      C_EXP         = 8,
  parameter int unsigned      C_MANT        = 23,
  parameter int unsigned      C_CMD         = 4,
  parameter logic [C_CMD-1:0] C_FPU_ADD_CMD = C_CMD'(0),
  parameter logic [C_CMD-1:0] C_FPU_SUB_CMD = C_CMD'(1),
  parameter logic [C_CMD-1:0] C_FPU_MUL_CMD = C_CMD'(2),
  parameter logic [C_CMD-1:0] C_FPU_DIV_CMD = C_CMD'(3),
  parameter logic [C_CMD-1:0] C_FPU_I2F_CMD = C_CMD'(4),
  parameter logic [C_CMD-1:0] C_FPU_F2I_CMD = C_CMD'(5),
  parameter int unsigned      C_CNT         = 16
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic              In_valid_SI,
  output logic              In_ready_SO,
  input  logic              Sign_a_DI,
  input  logic              Sign_b_DI,
  input  logic [C_EXP-1:0]  Exp_a_DI,
  input  logic [C_EXP-1:0]  Exp_b_DI,
  input  logic [C_MANT:0]   Mant_a_DI,
  input  logic [C_MANT:0]   Mant_b_DI,
  input  logic [C_MANT:0]   Mant_norm_DI,
  input  logic [C_CMD-1:0]  Op_SI,
  input  logic              Mant_rounded_SI,
  input  logic              Exp_OF_SI,
  input  logic              Exp_UF_SI,
  input  logic [4:0]        Conv_flags_DI,
  output logic              Out_valid_SO,
  input  logic              Out_ready_SI,
  output logic              Exp_toZero_SO,
  output logic              Exp_toInf_SO,
  output logic              Mant_toZero_SO,
  output logic              NaN_SO,
  output logic [4:0]        Flags_DO,
  output logic [4:0]        Fflags_DO,
  input  logic              Fflags_clr_SI,
  input  logic              Fflags_wr_SI,
  input  logic [4:0]        Fflags_wdata_DI,
  output logic [C_CNT-1:0]  Nv_count_DO
);

  logic w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_snan_a, w_snan_b, w_zero_a, w_zero_b;
  logic w_add, w_mul, w_div, w_i2f, w_f2i, w_arith, w_any_nan;
  logic w_nv, w_dz, w_of, w_uf, w_nx, w_nan, w_inf_exact, w_mant_to_zero, w_exp_to_inf;
  logic w_exp_to_zero, w_accept, w_retire;
  logic [4:0] w_retire_flags, w_fflags_d;

  logic             r_valid, r_exp_to_zero, r_exp_to_inf, r_mant_to_zero, r_nan;
  logic [4:0]       r_flags, r_fflags;
  logic [C_CNT-1:0] r_nv_cnt;

  assign w_inf_a  = (&Exp_a_DI) & (Mant_a_DI[C_MANT-1:0] == '0);
  assign w_inf_b  = (&Exp_b_DI) & (Mant_b_DI[C_MANT-1:0] == '0);
  assign w_nan_a  = (&Exp_a_DI) & (Mant_a_DI[C_MANT-1:0] != '0);
  assign w_nan_b  = (&Exp_b_DI) & (Mant_b_DI[C_MANT-1:0] != '0);
  assign w_snan_a = w_nan_a & ~Mant_a_DI[C_MANT-1];
  assign w_snan_b = w_nan_b & ~Mant_b_DI[C_MANT-1];
  assign w_zero_a = (Exp_a_DI == '0) & (Mant_a_DI == '0);
  assign w_zero_b = (Exp_b_DI == '0) & (Mant_b_DI == '0);

  assign w_add     = (Op_SI == C_FPU_ADD_CMD) | (Op_SI == C_FPU_SUB_CMD);
  assign w_mul     = (Op_SI == C_FPU_MUL_CMD);
  assign w_div     = (Op_SI == C_FPU_DIV_CMD);
  assign w_i2f     = (Op_SI == C_FPU_I2F_CMD);
  assign w_f2i     = (Op_SI == C_FPU_F2I_CMD);
  assign w_arith   = w_add | w_mul | w_div;
  assign w_any_nan = w_nan_a | w_nan_b;

  assign w_nv = (w_arith & (w_snan_a | w_snan_b))
              | (w_add & w_inf_a & w_inf_b & (Sign_a_DI ^ Sign_b_DI))
              | (w_mul & ((w_inf_a & w_zero_b) | (w_zero_a & w_inf_b)))
              | (w_div & ((w_zero_a & w_zero_b) | (w_inf_a & w_inf_b)))
              | (w_f2i & Conv_flags_DI[4]);
  assign w_dz = w_div & w_zero_b & ~w_zero_a & ~w_inf_a & ~w_nan_a;
  assign w_of = w_f2i ? Conv_flags_DI[2] : (Exp_OF_SI & (Mant_norm_DI != '0) & ~w_any_nan);
  assign w_uf = w_f2i ? Conv_flags_DI[1] : (Exp_UF_SI & Mant_rounded_SI);
  assign w_nx = w_f2i ? Conv_flags_DI[0] : (Mant_rounded_SI | w_of);

  // Finite/Inf quotient is zero, so only an infinite dividend propagates Inf through DIV.
  assign w_inf_exact    = ((w_add | w_mul) & (w_inf_a | w_inf_b)) | (w_div & w_inf_a);
  assign w_nan          = w_nv | (w_any_nan & ~w_f2i);
  assign w_mant_to_zero = (w_inf_exact | w_dz | w_of) & ~w_nan;
  assign w_exp_to_inf   = w_mant_to_zero | w_nan;
  assign w_exp_to_zero  = (w_i2f & ~Sign_a_DI & (Mant_a_DI == '0))
                        | Exp_UF_SI | ((Mant_norm_DI == '0) & ~w_exp_to_inf);

  assign In_ready_SO    = ~r_valid | Out_ready_SI;
  assign w_accept       = In_valid_SI & In_ready_SO;
  assign w_retire       = r_valid & Out_ready_SI;
  assign w_retire_flags = w_retire ? r_flags : 5'b0;

  always_comb begin
    w_fflags_d = r_fflags | w_retire_flags;
    if (Fflags_clr_SI) begin
      w_fflags_d = w_retire_flags;
    end else if (Fflags_wr_SI) begin
      w_fflags_d = Fflags_wdata_DI | w_retire_flags;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_valid        <= 1'b0;
      r_exp_to_zero  <= 1'b0;
      r_exp_to_inf   <= 1'b0;
      r_mant_to_zero <= 1'b0;
      r_nan          <= 1'b0;
      r_flags        <= 5'b0;
      r_fflags       <= 5'b0;
      r_nv_cnt       <= '0;
    end else begin
      r_valid  <= w_accept | (r_valid & ~Out_ready_SI);
      r_fflags <= w_fflags_d;
      if (w_accept) begin
        r_exp_to_zero  <= w_exp_to_zero;
        r_exp_to_inf   <= w_exp_to_inf;
        r_mant_to_zero <= w_mant_to_zero;
        r_nan          <= w_nan;
        r_flags        <= {w_nv, w_dz, w_of, w_uf, w_nx};
      end
      if (w_retire && r_flags[4] && !(&r_nv_cnt)) begin
        r_nv_cnt <= r_nv_cnt + C_CNT'(1);
      end
    end
  end

  assign Out_valid_SO   = r_valid;
  assign Exp_toZero_SO  = r_exp_to_zero;
  assign Exp_toInf_SO   = r_exp_to_inf;
  assign Mant_toZero_SO = r_mant_to_zero;
  assign NaN_SO         = r_nan;
  assign Flags_DO       = r_flags;
  assign Fflags_DO      = r_fflags;
  assign Nv_count_DO    = r_nv_cnt;

endmodule

// File: tb/tb_fpexc_pipe.sv
// Directed bench for fpexc_pipe: special-operand flags, handshake back-pressure,
// sticky flag write/clear priority, saturating NV counter and asynchronous reset.
module tb_fpexc_pipe;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  localparam logic [31:0] F_PINF = 32'h7F80_0000;
  localparam logic [31:0] F_NINF = 32'hFF80_0000;
  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_TWO  = 32'h4000_0000;
  localparam logic [31:0] F_ZERO = 32'h0000_0000;
  localparam logic [31:0] F_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] F_SNAN = 32'h7F80_0001;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [23:0] mant_a, mant_b, mant_norm;
  logic [3:0]  op;
  logic        mant_rounded, exp_of, exp_uf;
  logic [4:0]  conv_flags;
  logic        exp_to_zero, exp_to_inf, mant_to_zero, nan;
  logic [4:0]  flags, fflags, fflags_wdata;
  logic        fflags_clr, fflags_wr;
  logic [1:0]  nv_count;

  int n_tests = 0;
  int n_fail  = 0;

  fpexc_pipe #(.C_CNT(2)) u_dut (
    .Clk_CI          (clk),
    .Rst_RBI         (rst_n),
    .In_valid_SI     (in_valid),
    .In_ready_SO     (in_ready),
    .Sign_a_DI       (sign_a),
    .Sign_b_DI       (sign_b),
    .Exp_a_DI        (exp_a),
    .Exp_b_DI        (exp_b),
    .Mant_a_DI       (mant_a),
    .Mant_b_DI       (mant_b),
    .Mant_norm_DI    (mant_norm),
    .Op_SI           (op),
    .Mant_rounded_SI (mant_rounded),
    .Exp_OF_SI       (exp_of),
    .Exp_UF_SI       (exp_uf),
    .Conv_flags_DI   (conv_flags),
    .Out_valid_SO    (out_valid),
    .Out_ready_SI    (out_ready),
    .Exp_toZero_SO   (exp_to_zero),
    .Exp_toInf_SO    (exp_to_inf),
    .Mant_toZero_SO  (mant_to_zero),
    .NaN_SO          (nan),
    .Flags_DO        (flags),
    .Fflags_DO       (fflags),
    .Fflags_clr_SI   (fflags_clr),
    .Fflags_wr_SI    (fflags_wr),
    .Fflags_wdata_DI (fflags_wdata),
    .Nv_count_DO     (nv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op     = o;
    sign_a = a[31];
    exp_a  = a[30:23];
    mant_a = {|a[30:23], a[22:0]};
    sign_b = b[31];
    exp_b  = b[30:23];
    mant_b = {|b[30:23], b[22:0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mant_norm = 24'h80_0000; mant_rounded = 1'b0; exp_of = 1'b0; exp_uf = 1'b0;
    conv_flags = 5'b0; fflags_clr = 1'b0; fflags_wr = 1'b0; fflags_wdata = 5'b0;
    set_op(OP_ADD, F_ONE, F_ONE);
    #3;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_flags", flags, 0);
    check_eq("rst_fflags", fflags, 0);
    check_eq("rst_nvcnt", nv_count, 0);
    check_eq("rst_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 0);
    #10;
    @(negedge clk) rst_n = 1'b1;
    step();

    // +Inf + -Inf: invalid
    set_op(OP_ADD, F_PINF, F_NINF);
    issue();
    check_eq("inf_sub_valid", out_valid, 1);
    check_eq("inf_sub_flags", flags, 5'b10000);
    check_eq("inf_sub_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 4'b0101);
    step();
    check_eq("inf_sub_fflags", fflags, 5'b10000);
    check_eq("inf_sub_nvcnt", nv_count, 1);
    check_eq("inf_sub_retired", out_valid, 0);

    // 1.0 / +0: divide by zero
    set_op(OP_DIV, F_ONE, F_ZERO);
    issue();
    check_eq("dz_flags", flags, 5'b01000);
    check_eq("dz_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 4'b0110);
    step();
    check_eq("dz_fflags", fflags, 5'b11000);

    // qNaN operand: no NV, NaN result
    set_op(OP_MUL, F_QNAN, F_TWO);
    issue();
    check_eq("qnan_flags", flags, 5'b00000);
    check_eq("qnan_nan", nan, 1);
    step();

    set_op(OP_MUL, F_SNAN, F_TWO);
    issue();
    check_eq("snan_flags", flags, 5'b10000);
    check_eq("snan_nan", nan, 1);
    step();
    check_eq("snan_nvcnt", nv_count, 2);

    // Overflow with finite operands
    set_op(OP_ADD, F_ONE, F_ONE);
    exp_of = 1'b1;
    issue();
    check_eq("of_flags", flags, 5'b00101);
    check_eq("of_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 4'b0110);
    step();

    // Overflow suppressed by a NaN operand
    set_op(OP_ADD, F_QNAN, F_ONE);
    issue();
    check_eq("of_nan_flags", flags, 5'b00000);
    check_eq("of_nan_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 4'b0101);
    step();
    exp_of = 1'b0;

    // Underflow
    set_op(OP_ADD, F_ONE, F_ONE);
    exp_uf = 1'b1; mant_rounded = 1'b1;
    issue();
    check_eq("uf_flags", flags, 5'b00011);
    check_eq("uf_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 4'b1000);
    step();
    exp_uf = 1'b0; mant_rounded = 1'b0;

    // Zero normalized mantissa forces zero exponent
    mant_norm = 24'h0;
    issue();
    check_eq("zero_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 4'b1000);
    check_eq("zero_flags", flags, 5'b00000);
    step();
    mant_norm = 24'h80_0000;

    // Clear with no retire
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check_eq("clr_idle", fflags, 5'b00000);

    // Back-pressure: first result held, second accepted in retire cycle
    out_ready = 1'b0;
    set_op(OP_DIV, F_ONE, F_ZERO);
    issue();
    set_op(OP_MUL, F_PINF, F_ZERO);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_ready", in_ready, 0);
      check_eq("bp_flags", flags, 5'b01000);
      check_eq("bp_mtz", mant_to_zero, 1);
    end
    check_eq("bp_fflags_hold", fflags, 5'b00000);
    out_ready = 1'b1;
    #1;
    check_eq("bp_ready_comb", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("bp_second_valid", out_valid, 1);
    check_eq("bp_second_flags", flags, 5'b10000);
    check_eq("bp_first_retired", fflags, 5'b01000);
    step();
    check_eq("bp_both_retired", fflags, 5'b11000);
    check_eq("bp_drained", out_valid, 0);
    check_eq("nvcnt_3", nv_count, 3);

    // Fourth NV retirement saturates
    set_op(OP_MUL, F_ZERO, F_PINF);
    issue();
    step();
    check_eq("nvcnt_sat", nv_count, 3);

    // Write with concurrent NX retirement, then clear
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    set_op(OP_ADD, F_ONE, F_ONE);
    mant_rounded = 1'b1;
    issue();
    check_eq("nx_flags", flags, 5'b00001);
    fflags_wr = 1'b1; fflags_wdata = 5'b00100;
    step();
    fflags_wr = 1'b0; mant_rounded = 1'b0;
    check_eq("wr_retire", fflags, 5'b00101);
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check_eq("clr_after_wr", fflags, 5'b00000);
    check_eq("nvcnt_after_clr", nv_count, 3);

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    set_op(OP_DIV, F_ONE, F_ZERO);
    issue();
    check_eq("hold_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_ready", in_ready, 1);
    check_eq("arst_flags", flags, 0);
    check_eq("arst_fflags", fflags, 0);
    check_eq("arst_nvcnt", nv_count, 0);
    check_eq("arst_ctrl", {exp_to_zero, exp_to_inf, mant_to_zero, nan}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
